// File: rtl/cgra_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cgra_prog_pkg (package)
// Purpose : Shared definitions for the tile program loader: loader FSM state
//           encoding, default field widths, the broadcast tile ID, and the
//           CRC-8 polynomial with a serial step helper.
// Revision: 1.0 - initial release
// ============================================================================
package cgra_prog_pkg;

  localparam int DEF_ID_W   = 8;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_INS_W  = 64;

  localparam logic [DEF_ID_W-1:0] BROADCAST_ID = '1;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ID   = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CRC  = 3'd4
  } prog_state_e;

  // One bit of an MSB-first shift CRC-8: feedback is the outgoing MSB XOR the
  // incoming bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_crc8.sv
`default_nettype none
// ============================================================================
// Module  : prog_crc8
// Purpose : Serial bit-at-a-time CRC-8 accumulator (poly 0x07, init 0x00).
// Ports   : clk, rst     - clock, synchronous active-high reset
//           clear        - restart from the init value
//           enable       - fold din into the CRC this cycle
//           din          - serial input bit
//           crc          - current CRC value
// Note    : clear together with enable folds din into a fresh CRC, so the first
//           bit of a frame can be accepted without a separate clear cycle.
// Revision: 1.0 - initial release
// ============================================================================
module prog_crc8
  import cgra_prog_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= 8'h00;
    end else if (enable) begin
      crc <= crc8_step(clear ? 8'h00 : crc, din);
    end else if (clear) begin
      crc <= 8'h00;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tile_prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : tile_prog_loader
// Purpose : Deserializes the daisy-chained programming bitstream into framed
//           instruction-memory writes. Frame = ID | ADDR | DATA (each field
//           LSB-first); frames whose ID equals TILE_ID or BROADCAST produce a
//           one-cycle write strobe the cycle after the last frame bit.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           program_mode    - bitstream valid, one bit per clock
//           data_in         - serial bitstream
//           data_out        - data_in delayed one clock (0 outside program mode)
//           ins_wr_en/addr/data - instruction memory write port
//           load_busy       - frame partially received
//           frame_err       - one-cycle pulse on abort (or CRC mismatch)
//           words_loaded    - accepted writes since program_mode rose (saturating)
// Config  : PROG_LOADER_CRC_EN - appends an 8-bit CRC-8 field to each frame;
//           the write is issued only when the received CRC matches.
// Revision: 1.0 - initial release
// ============================================================================
module tile_prog_loader
  import cgra_prog_pkg::*;
#(
  parameter int                TILE_ID   = 0,
  parameter int                ID_W      = DEF_ID_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                INS_W     = DEF_INS_W,
  parameter logic [ID_W-1:0]   BROADCAST = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              program_mode,
  input  logic              data_in,
  output logic              data_out,
  output logic              ins_wr_en,
  output logic [ADDR_W-1:0] ins_wr_addr,
  output logic [INS_W-1:0]  ins_wr_data,
  output logic              load_busy,
  output logic              frame_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int MAX_FIELD = (INS_W > ID_W) ? ((INS_W > ADDR_W) ? INS_W : ADDR_W)
                                            : ((ID_W > ADDR_W) ? ID_W : ADDR_W);
  localparam int CNT_W = (MAX_FIELD > 1) ? $clog2(MAX_FIELD) : 1;

  localparam logic [CNT_W-1:0] ID_LAST   = CNT_W'(ID_W - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(INS_W - 1);
  localparam logic [ADDR_W:0]  WL_MAX    = (ADDR_W+1)'(2 ** ADDR_W);

  prog_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   id_sr;
  logic [ADDR_W-1:0] addr_sr;
  // Holds the first INS_W-1 data bits; the final bit is taken straight from
  // data_in when the word completes.
  logic [INS_W-2:0]  data_sr;
  logic              pm_q;

  logic [INS_W-1:0]  data_word;
  logic              id_match;
  logic [ADDR_W:0]   words_inc;

  assign data_word = {data_in, data_sr};
  assign id_match  = (id_sr == ID_W'(TILE_ID)) || (id_sr == BROADCAST);
  assign words_inc = (words_loaded == WL_MAX) ? words_loaded : words_loaded + 1'b1;

  // ID state with a zero counter is the frame boundary after a completed
  // frame, so it does not count as mid-frame.
  assign load_busy = (state != ST_IDLE) && !((state == ST_ID) && (cnt == '0));

`ifdef PROG_LOADER_CRC_EN
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(7);

  logic [INS_W-1:0] word_hold;
  logic [6:0]       crc_sr;
  logic [7:0]       crc_rx;
  logic [7:0]       crc_calc;
  logic             crc_en;
  logic             crc_clr;

  assign crc_rx  = {data_in, crc_sr};
  assign crc_en  = program_mode && (state != ST_CRC);
  assign crc_clr = program_mode && ((state == ST_IDLE) || ((state == ST_ID) && (cnt == '0)));

  prog_crc8 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clear  (crc_clr),
    .enable (crc_en),
    .din    (data_in),
    .crc    (crc_calc)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      id_sr        <= '0;
      addr_sr      <= '0;
      data_sr      <= '0;
      pm_q         <= 1'b0;
      data_out     <= 1'b0;
      ins_wr_en    <= 1'b0;
      ins_wr_addr  <= '0;
      ins_wr_data  <= '0;
      frame_err    <= 1'b0;
      words_loaded <= '0;
`ifdef PROG_LOADER_CRC_EN
      word_hold    <= '0;
      crc_sr       <= '0;
`endif
    end else begin
      pm_q      <= program_mode;
      data_out  <= program_mode & data_in;
      ins_wr_en <= 1'b0;
      frame_err <= 1'b0;

      if (program_mode && !pm_q) begin
        words_loaded <= '0;
      end

      if (!program_mode) begin
        if (load_busy) begin
          frame_err <= 1'b1;
        end
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_ID: begin
            id_sr <= {data_in, id_sr[ID_W-1:1]};
            if (cnt == ID_LAST) begin
              state <= ST_ADDR;
              cnt   <= '0;
            end else begin
              state <= ST_ID;
              cnt   <= cnt + CNT_W'(1);
            end
          end

          ST_ADDR: begin
            addr_sr <= {data_in, addr_sr[ADDR_W-1:1]};
            if (cnt == ADDR_LAST) begin
              state <= ST_DATA;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          ST_DATA: begin
            data_sr <= data_word[INS_W-1:1];
            if (cnt == DATA_LAST) begin
              cnt <= '0;
`ifdef PROG_LOADER_CRC_EN
              word_hold <= data_word;
              state     <= ST_CRC;
`else
              state <= ST_ID;
              if (id_match) begin
                ins_wr_en    <= 1'b1;
                ins_wr_addr  <= addr_sr;
                ins_wr_data  <= data_word;
                words_loaded <= words_inc;
              end
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

`ifdef PROG_LOADER_CRC_EN
          ST_CRC: begin
            crc_sr <= crc_rx[7:1];
            if (cnt == CRC_LAST) begin
              state <= ST_ID;
              cnt   <= '0;
              if (crc_rx != crc_calc) begin
                frame_err <= 1'b1;
              end else if (id_match) begin
                ins_wr_en    <= 1'b1;
                ins_wr_addr  <= addr_sr;
                ins_wr_data  <= word_hold;
                words_loaded <= words_inc;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
`endif

          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tile_prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_tile_prog_loader
// Purpose : Self-checking bench for tile_prog_loader (TILE_ID = 2). Expected
//           writes are queued when a frame is shifted in and compared when the
//           write strobe appears. PROG_LOADER_CRC_EN selects the CRC build.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tile_prog_loader;

  localparam int ID_W    = 8;
  localparam int ADDR_W  = 6;
  localparam int INS_W   = 64;
  localparam int TILE_ID = 2;
`ifdef PROG_LOADER_CRC_EN
  localparam int FRAME_BITS = 86;
`else
  localparam int FRAME_BITS = 78;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              program_mode = 1'b0;
  logic              data_in = 1'b0;
  logic              data_out;
  logic              ins_wr_en;
  logic [ADDR_W-1:0] ins_wr_addr;
  logic [INS_W-1:0]  ins_wr_data;
  logic              load_busy;
  logic              frame_err;
  logic [ADDR_W:0]   words_loaded;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INS_W-1:0]  data;
    int                cyc;
  } wr_t;

  wr_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   err_cycles = 0;
  int   last_sc = 0;
  int   prev_sc = 0;
  bit   mon_en = 1'b0;
  logic exp_dout = 1'b0;

  tile_prog_loader #(
    .TILE_ID   (TILE_ID),
    .ID_W      (ID_W),
    .ADDR_W    (ADDR_W),
    .INS_W     (INS_W),
    .BROADCAST (8'hFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .program_mode (program_mode),
    .data_in      (data_in),
    .data_out     (data_out),
    .ins_wr_en    (ins_wr_en),
    .ins_wr_addr  (ins_wr_addr),
    .ins_wr_data  (ins_wr_data),
    .load_busy    (load_busy),
    .frame_err    (frame_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    exp_dout <= rst ? 1'b0 : (program_mode ? data_in : 1'b0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC-8, poly 0x07, init 0, bits fed in transmit order.
  function automatic logic [7:0] crc8_ref(input logic [77:0] bits);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < 78; i++) begin
      fb = c[7] ^ bits[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  // Output monitor: data_out forwarding every cycle, strobes against the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      check("data_out", {63'd0, data_out}, {63'd0, exp_dout});
      if (frame_err) err_cycles++;
      if (ins_wr_en) begin
        wr_t e;
        prev_sc = last_sc;
        last_sc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {58'd0, ins_wr_addr}, {58'd0, e.addr});
          check("wr_data", ins_wr_data, e.data);
          check("wr_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    program_mode = 1'b1;
    data_in      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    program_mode = 1'b0;
    data_in      = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [5:0] addr,
                            input logic [63:0] data, input bit corrupt);
    logic [85:0] fb;
    fb         = '0;
    fb[7:0]    = id;
    fb[13:8]   = addr;
    fb[77:14]  = data;
    fb[85:78]  = crc8_ref(fb[77:0]);
    if (corrupt) fb[30] = ~fb[30];
    for (int i = 0; i < FRAME_BITS; i++) begin
      send_bit(fb[i]);
      if (i == 20) check("busy_mid_frame", {63'd0, load_busy}, 64'd1);
    end
    // The strobe for this frame is already visible now, one cycle after the last bit.
    if ((id == 8'(TILE_ID) || id == 8'hFF) && !corrupt) exp_q.push_back('{addr, data, cyc});
    check("busy_frame_end", {63'd0, load_busy}, 64'd0);
    check("err_after_frame", {63'd0, frame_err}, {63'd0, corrupt});
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, {63'd0, ins_wr_en}, 64'd0);
    check({tag, "_wr_addr"}, {58'd0, ins_wr_addr}, 64'd0);
    check({tag, "_wr_data"}, ins_wr_data, 64'd0);
    check({tag, "_busy"}, {63'd0, load_busy}, 64'd0);
    check({tag, "_err"}, {63'd0, frame_err}, 64'd0);
    check({tag, "_words"}, {57'd0, words_loaded}, 64'd0);
    check({tag, "_data_out"}, {63'd0, data_out}, 64'd0);
  endtask

  initial begin
    int e0;

    // Reset with program_mode and data_in active: reset must dominate.
    rst          = 1'b1;
    program_mode = 1'b1;
    data_in      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    program_mode = 1'b0;
    data_in      = 1'b0;
    rst          = 1'b0;
    mon_en       = 1'b1;
    idle(2);

    // Matching frame.
    send_frame(8'h02, 6'd5, 64'h0123_4567_89AB_CDEF, 1'b0);
    check("words_after_match", {57'd0, words_loaded}, 64'd1);
    idle(2);
    check("words_hold_idle", {57'd0, words_loaded}, 64'd1);
    check("no_err_clean_end", 64'(err_cycles), 64'd0);

    // Non-matching frame in a new session: no write, counter restarted.
    send_frame(8'h03, 6'd7, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    check("words_after_nomatch", {57'd0, words_loaded}, 64'd0);
    check("wr_addr_held", {58'd0, ins_wr_addr}, 64'd5);
    idle(2);

    // Back-to-back broadcast frames.
    send_frame(8'hFF, 6'd0, 64'h1111_2222_3333_4444, 1'b0);
    send_frame(8'hFF, 6'd63, 64'hFFFF_0000_AAAA_5555, 1'b0);
    idle(1);
    check("words_back_to_back", {57'd0, words_loaded}, 64'd2);
    check("strobe_spacing", 64'(last_sc - prev_sc), 64'(FRAME_BITS));
    idle(1);

    // Abort after 40 bits.
    e0 = err_cycles;
    send_partial(40);
    check("busy_before_abort", {63'd0, load_busy}, 64'd1);
    idle(1);
    check("abort_err_pulse", {63'd0, frame_err}, 64'd1);
    check("abort_busy_clear", {63'd0, load_busy}, 64'd0);
    idle(1);
    check("abort_err_one_cycle", {63'd0, frame_err}, 64'd0);
    check("abort_err_count", 64'(err_cycles - e0), 64'd1);
    send_frame(8'h02, 6'd9, 64'h0F0E_0D0C_0B0A_0908, 1'b0);
    check("words_after_abort", {57'd0, words_loaded}, 64'd1);
    idle(2);

    // Reset in the middle of the DATA field.
    send_partial(50);
    rst     = 1'b1;
    data_in = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    rst = 1'b0;
    send_frame(8'h02, 6'd17, 64'h8000_0000_0000_0001, 1'b0);
    check("words_after_midreset", {57'd0, words_loaded}, 64'd1);
    idle(2);

`ifdef PROG_LOADER_CRC_EN
    // Corrupted DATA bit: CRC mismatch, error pulse, no write.
    send_frame(8'h02, 6'd3, 64'h1234_5678_9ABC_DEF0, 1'b1);
    check("words_after_crc_fail", {57'd0, words_loaded}, 64'd0);
    send_frame(8'h02, 6'd4, 64'h1234_5678_9ABC_DEF0, 1'b0);
    check("words_after_crc_ok", {57'd0, words_loaded}, 64'd1);
    idle(2);
`endif

    // Saturation: 65 accepted writes in one session.
    for (int i = 0; i < 65; i++) begin
      send_frame(8'hFF, 6'(i), {$urandom, $urandom}, 1'b0);
    end
    check("words_saturated", {57'd0, words_loaded}, 64'd64);
    idle(2);
    check("words_sat_hold", {57'd0, words_loaded}, 64'd64);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tile_prog_loader.md
Name: tile_prog_loader

Overview:
Serial program loader that sits directly upstream of a tile's instruction memory. It deserializes the daisy-chained programming bitstream into framed instruction writes. It filters frames by tile ID and issues one-cycle write strobes (address + 64-bit instruction word) into the tile's insmemory. A one-cycle-delayed copy of the serial input is forwarded to the next tile in the chain.

Parameters:
TILE_ID, 0, ID of this tile; frames whose ID field matches (or equals BROADCAST) are written
ID_W, 8, width of frame tile-ID field
ADDR_W, 6, width of instruction address field (64-entry insmemory)
INS_W, 64, instruction word width
BROADCAST, all-ones of ID_W, ID value accepted by every tile

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
program_mode  in  1  high while the bitstream is being shifted; one bit per clock
data_in  in  1  serial bitstream, LSB-first per field
data_out  out  1  data_in registered one cycle (daisy chain to next tile)
ins_wr_en  out  1  one-cycle write strobe to instruction memory
ins_wr_addr  out  ADDR_W  instruction address for the write
ins_wr_data  out  INS_W  instruction word for the write
load_busy  out  1  high while a frame is partially received
frame_err  out  1  one-cycle pulse: frame aborted (or CRC fail when enabled)
words_loaded  out  ADDR_W+1  count of accepted writes since program_mode rose; saturates at 2^ADDR_W

Behaviour:
- Reset: all outputs 0; FSM to IDLE; shift register and bit counter cleared. Reset overrides every other input in the same cycle.
- Frame layout, in bit order: ID (ID_W bits), ADDR (ADDR_W bits), DATA (INS_W bits). Default frame = 78 bits. Each field is LSB-first.
- One bit is sampled per posedge while program_mode=1. No bits are sampled while program_mode=0.
- FSM states: IDLE -> ID -> ADDR -> DATA -> (CRC when enabled) -> ID.
  - IDLE->ID: the sampled bit in the first program_mode=1 cycle is ID bit 0.
  - Each state holds for exactly its field width, tracked by a bit counter cleared at every state change.
- Commit: the last DATA bit is sampled in cycle N. In cycle N+1, ins_wr_en=1 for exactly one cycle, with addr/data valid, only if ID==TILE_ID or ID==BROADCAST. On a non-matching ID, no strobe is issued and the frame is silently consumed.
- Back-to-back frames are allowed: the bit sampled in cycle N+1 is ID bit 0 of the next frame. There are no stall cycles.
- ins_wr_addr and ins_wr_data hold their last written value between strobes.
- load_busy=1 whenever FSM is not IDLE and the bit counter, or any field, is mid-frame. It is 0 after a frame completes exactly.
- Abort: program_mode falls while load_busy=1. The FSM returns to IDLE, frame_err pulses one cycle (the cycle after the fall), and no write occurs.
- Clean end: program_mode falls on a frame boundary. The FSM returns to IDLE with no error.
- words_loaded clears on the rising edge of program_mode. It increments on each issued strobe and saturates at 2^ADDR_W.
- Addresses are not checked for duplicates: a later write to the same address overwrites the earlier one.
- data_out = data_in delayed one clock when program_mode=1; 0 otherwise. Forwarding does not depend on ID match.

Optional Feature:
Macro PROG_LOADER_CRC_EN.
- Defined: each frame is extended by an 8-bit CRC-8 (poly 0x07, init 0x00) computed over ID|ADDR|DATA in transmit bit order. The CRC is transmitted LSB-first and received in state CRC. The commit strobe moves to the cycle after the last CRC bit and is issued only on CRC match. On mismatch, frame_err pulses that cycle and no write occurs.
- Undefined: there is no CRC state or field, the frame is 78 bits, and the commit timing is as above.

Decomposition:
- Shared package cgra_prog_pkg holds:
  - FSM state enum (IDLE, ID, ADDR, DATA, CRC)
  - INS_W/ADDR_W/ID_W defaults and BROADCAST constant
  - CRC8_POLY
- One natural sub-module: prog_crc8, a serial bit-at-a-time CRC-8 with clear/enable. It is instantiated only under PROG_LOADER_CRC_EN.

Test Plan:
- TILE_ID=2; shift frame ID=0x02, ADDR=5, DATA=0x0123_4567_89AB_CDEF -> one ins_wr_en cycle exactly 1 clock after last bit, addr=5, data=0x0123456789ABCDEF, words_loaded=1.
- Frame with ID=0x03 at TILE_ID=2 -> no strobe, words_loaded stays 0; data_out equals data_in delayed 1 cycle throughout.
- Two back-to-back frames, ID=0xFF ADDR=0 and ADDR=63 -> strobes 78 cycles apart, addresses 0 then 63, words_loaded=2.
- program_mode dropped after 40 bits -> frame_err one-cycle pulse, no strobe, FSM IDLE; a new full frame afterwards writes correctly.
- rst asserted mid-DATA field -> next cycle all outputs 0, no strobe; the next frame decodes from ID bit 0.
- With PROG_LOADER_CRC_EN: valid CRC -> strobe 1 cycle after 86th bit; flip one DATA bit -> frame_err pulse, no strobe.
